// File: rtl/fetch_unit.sv
// Instruction fetch: requests one word at pc, holds it for decode until stall drops, then retires and advances pc.
// Latency: instr valid the cycle after imem_ack; stall in HOLD freezes pc/instr/valid; one instruction per 2 cycles at best.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pcplus4,
  output logic        valid,
  output logic [31:0] retired
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q;
  logic [31:0] retired_q;
  logic        valid_q;
  logic        req_q;

  assign pcplus4 = pc_q + 32'd4;

  // Jump outranks branch; both are only consumed on the retiring cycle.
  always_comb begin
    pc_d = pcplus4;
    if (jump) begin
      pc_d = {pcplus4[31:28], instr_q[25:0], 2'b00};
    end else if (pcsrc) begin
      pc_d = pcplus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      retired_q <= '0;
      req_q     <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          // An ack only counts once the request is actually on the bus.
          if (req_q && imem_ack) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= HOLD;
          end else begin
            req_q <= 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_q      <= pc_d;
            retired_q <= retired_q + 32'd1;
            valid_q   <= 1'b0;
            req_q     <= 1'b1;
            state_q   <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign op        = instr_q[31:26];
  assign funct     = instr_q[5:0];
  assign valid     = valid_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; a scoreboard holds expected request addresses and presented instructions.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pcsrc;
  logic        jump;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pcplus4;
  logic        valid;
  logic [31:0] retired;

  fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .stall     (stall),
    .pcsrc     (pcsrc),
    .jump      (jump),
    .instr     (instr),
    .op        (op),
    .funct     (funct),
    .pcplus4   (pcplus4),
    .valid     (valid),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  int          ntests = 0;
  int          nfail  = 0;
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_ins_q[$];
  logic [31:0] exp_retired = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every new request and every newly presented instruction is scored.
  logic        req_prev   = 1'b0;
  logic        valid_prev = 1'b0;
  logic [63:0] mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      req_prev   = 1'b0;
      valid_prev = 1'b0;
    end else begin
      if (imem_req && !req_prev) begin
        if (exp_addr_q.size() == 0) chk("unexpected_req", imem_addr, 32'hxxxx_xxxx);
        else chk("req_addr", imem_addr, exp_addr_q.pop_front());
      end
      if (valid && !valid_prev) begin
        if (exp_ins_q.size() == 0) chk("unexpected_valid", instr, 32'hxxxx_xxxx);
        else begin
          mon_e = exp_ins_q.pop_front();
          chk("mon_instr", instr, mon_e[63:32]);
          chk("mon_op", {26'd0, op}, {26'd0, mon_e[63:58]});
          chk("mon_funct", {26'd0, funct}, {26'd0, mon_e[37:32]});
          chk("mon_pcplus4", pcplus4, mon_e[31:0]);
        end
      end
      req_prev   = imem_req;
      valid_prev = valid;
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imem_req) chk("req_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  // Ack after dly cycles of waiting; stall/pcsrc/jump are toggled as noise meanwhile.
  task automatic fetch(input logic [31:0] word, input logic [31:0] pc, input logic [31:0] pc4, input int dly);
    wait_req();
    for (int i = 0; i < dly; i++) begin
      stall = 1'b1; pcsrc = 1'b1; jump = 1'b1;
      chk("wait_req_stable", {31'd0, imem_req}, 32'd1);
      chk("wait_addr_stable", imem_addr, pc);
      @(posedge clk); #1;
    end
    pcsrc = 1'b0; jump = 1'b0; stall = 1'b1;
    exp_ins_q.push_back({word, pc4});
    imem_ack = 1'b1; imem_rdata = word;
    @(posedge clk); #1;
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    chk("valid_after_ack", {31'd0, valid}, 32'd1);
    chk("instr_latched", instr, word);
    chk("req_drop_in_hold", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic retire(input logic [31:0] word, input logic [31:0] pc, input int stalls,
                        input logic br, input logic jp, input logic [31:0] next_pc);
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1; pcsrc = i[0]; jump = ~i[0];
      @(posedge clk); #1;
      chk("stall_instr", instr, word);
      chk("stall_pc", imem_addr, pc);
      chk("stall_valid", {31'd0, valid}, 32'd1);
      chk("stall_retired", retired, exp_retired);
    end
    stall = 1'b0; pcsrc = br; jump = jp;
    exp_addr_q.push_back(next_pc);
    exp_retired = exp_retired + 32'd1;
    @(posedge clk); #1;
    stall = 1'b1; pcsrc = 1'b0; jump = 1'b0;
    chk("retire_valid", {31'd0, valid}, 32'd0);
    chk("retire_count", retired, exp_retired);
    chk("retire_next_pc", imem_addr, next_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; pcsrc = 1'b0; jump = 1'b0;
    #2;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    exp_addr_q.push_back(32'h0);
    reset = 1'b1;

    fetch(32'h0800_0010, 32'h0, 32'h4, 1);
    retire(32'h0800_0010, 32'h0, 0, 1'b0, 1'b1, 32'h40);

    fetch(32'h1000_0003, 32'h40, 32'h44, 0);
    retire(32'h1000_0003, 32'h40, 0, 1'b1, 1'b0, 32'h50);

    fetch(32'h1000_FFFB, 32'h50, 32'h54, 0);
    retire(32'h1000_FFFB, 32'h50, 0, 1'b1, 1'b0, 32'h40);

    fetch(32'h0800_0010, 32'h40, 32'h44, 4);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("stray_ack_instr", instr, 32'h0800_0010);
    retire(32'h0800_0010, 32'h40, 0, 1'b1, 1'b1, 32'h40);

    fetch(32'h0000_0020, 32'h40, 32'h44, 0);
    retire(32'h0000_0020, 32'h40, 5, 1'b0, 1'b0, 32'h44);

    fetch(32'h1000_FFED, 32'h44, 32'h48, 2);
    retire(32'h1000_FFED, 32'h44, 0, 1'b1, 1'b0, 32'hFFFF_FFFC);

    fetch(32'h0800_0020, 32'hFFFF_FFFC, 32'h0000_0000, 0);
    retire(32'h0800_0020, 32'hFFFF_FFFC, 0, 1'b0, 1'b1, 32'h80);

    // Reset while the request at 0x80 is outstanding.
    @(posedge clk); #2;
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_retired", retired, 32'd0);
    chk("midrst_addr", imem_addr, 32'd0);
    exp_retired = 32'd0;
    @(posedge clk); #1;
    chk("rst_ack_ignored", instr, 32'd0);
    imem_ack = 1'b0;
    exp_addr_q.push_back(32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);

    fetch(32'h2001_0005, 32'h0, 32'h4, 0);
    retire(32'h2001_0005, 32'h0, 0, 1'b0, 1'b0, 32'h4);

    @(negedge clk); #1;
    chk("scoreboard_drained", exp_addr_q.size() + exp_ins_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 imem_req  out  1  instruction-memory read request.
REQ-006 imem_addr  out  32  word address of the request; equals pc.
REQ-007 imem_ack  in  1  read-data-valid strobe from instruction memory.
REQ-008 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-009 stall  in  1  downstream hold; blocks retirement of the current instruction.
REQ-010 pcsrc  in  1  take the branch (branch & zero from decode/execute).
REQ-011 jump  in  1  take the jump.
REQ-012 instr  out  32  held instruction register.
REQ-013 op  out  6  instr[31:26], to the controller.
REQ-014 funct  out  6  instr[5:0], to the controller.
REQ-015 pcplus4  out  32  pc + 4 of the held instruction.
REQ-016 valid  out  1  instr/op/funct/pcplus4 are valid for decode.
REQ-017 retired  out  32  count of retired instructions.

Function
REQ-018 The block SHALL implement a two-state FSM: FETCH (awaiting memory) and HOLD (instruction presented downstream).
REQ-019 In FETCH the block SHALL drive imem_req=1 and imem_addr=pc, both stable until imem_ack.
REQ-020 On a cycle in FETCH with imem_ack=1 the block SHALL latch imem_rdata into instr and enter HOLD, with valid=1 from the next cycle.
REQ-021 In HOLD the block SHALL drive imem_req=0 and ignore imem_ack and imem_rdata.
REQ-022 In HOLD with stall=1 the block SHALL hold pc, instr and valid unchanged.
REQ-023 In HOLD with stall=0 the block SHALL retire: update pc, increment retired, return to FETCH, and drive valid=0 from the next cycle.
REQ-024 Next-pc priority at retirement SHALL be: jump=1 gives {pcplus4[31:28], instr[25:0], 2'b00}; else pcsrc=1 gives pcplus4 + (sign-extended instr[15:0] << 2); else pcplus4.
REQ-025 pcsrc and jump SHALL be sampled only on the retiring cycle; their values at any other time SHALL have no effect.
REQ-026 All pc arithmetic SHALL be 32-bit modulo 2^32; pc=32'hFFFF_FFFC SHALL give pcplus4=32'h0000_0000.
REQ-027 pcplus4 SHALL be combinationally pc+4 while valid=1; op and funct SHALL be direct slices of instr.
REQ-028 retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-029 Minimum throughput SHALL be one instruction per 2 cycles (ack in the first FETCH cycle, stall=0 in HOLD).
REQ-030 stall SHALL have no effect in FETCH.

Reset
REQ-031 reset=0 SHALL immediately force: state FETCH, pc=RESET_PC, instr=0, valid=0, retired=0, imem_req=0.
REQ-032 imem_req SHALL assert on the first rising clk after reset deasserts; reset during an outstanding request SHALL abandon it, and any ack arriving during reset SHALL be ignored.

Verification
REQ-033 Reset release, imem_ack returned 1 cycle after imem_req -> imem_addr=0, instr latched, valid=1, op=imem_rdata[31:26].
REQ-034 HOLD with instr=32'h1000_0003, pc=0x40, pcsrc=1, stall=0 -> next imem_addr=0x50, retired increments by 1.
REQ-035 HOLD with instr=32'h0800_0010, pc=0x40, jump=1 and pcsrc=1 -> next imem_addr=0x40 (jump wins).
REQ-036 stall=1 for 5 HOLD cycles then 0 -> pc, instr and valid held throughout; exactly one retirement.
REQ-037 ack delayed 4 cycles -> imem_req and imem_addr stable for all 5 cycles; a stray ack in HOLD -> instr unchanged.
REQ-038 reset asserted mid-FETCH with pc=0x80 -> imem_req=0 and valid=0 immediately; after release imem_addr=RESET_PC.
